// File: rtl/sb_pkg.sv
// Shared types and constants for the store buffer and its forwarding merge.
package sb_pkg;

  localparam int unsigned SB_LANES     = 4;
  localparam int unsigned SB_DEPTH_DEF = 4;
  localparam int unsigned SB_CNT_W     = 5;

  // One buffered store: word address, lane-aligned data, byte enables.
  typedef struct packed {
    logic [29:0]          addr;
    logic [31:0]          data;
    logic [SB_LANES-1:0]  be;
  } sb_entry_t;

endpackage

// File: rtl/sb_fwd_merge.sv
// Per-lane youngest-match merge of resident store-buffer entries for a load lookup.
module sb_fwd_merge
  import sb_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH_DEF,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  sb_entry_t            entries_i [DEPTH],
  input  logic [DEPTH-1:0]     valid_i,
  input  logic [PW-1:0]        age_i [DEPTH],
  input  logic [31:0]          ld_addr_i,
  output logic [31:0]          fwd_data_o,
  output logic [SB_LANES-1:0]  fwd_mask_o,
  output logic                 hit_o
);

  logic [DEPTH-1:0] match;
  logic             unused_lo;

  // Byte offset within the word does not affect matching.
  assign unused_lo = ^ld_addr_i[1:0];

  // Word-address match against resident entries only.
  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid_i[i] && (entries_i[i].addr == ld_addr_i[31:2]);
    end
  end

  assign hit_o = |match;

  // For each lane pick the matching entry with the highest age (youngest).
  always_comb begin
    logic          found;
    logic [PW-1:0] best;
    fwd_data_o = '0;
    fwd_mask_o = '0;
    found      = 1'b0;
    best       = '0;
    for (int l = 0; l < SB_LANES; l++) begin
      found = 1'b0;
      best  = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (match[i] && entries_i[i].be[l] && (!found || (age_i[i] > best))) begin
          found                = 1'b1;
          best                 = age_i[i];
          fwd_data_o[l*8 +: 8] = entries_i[i].data[l*8 +: 8];
        end
      end
      fwd_mask_o[l] = found;
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: FIFO of pending stores draining to data memory, with load lookup.
// Optional macro SB_FWD_EN: forward matching bytes to loads instead of stalling them.
module store_buffer
  import sb_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                st_valid,
  input  logic [31:0]         st_addr,
  input  logic [31:0]         st_data,
  input  logic [3:0]          st_be,
  output logic                st_ready,
  input  logic                ld_valid,
  input  logic [31:0]         ld_addr,
  output logic [31:0]         ld_fwd_data,
  output logic [3:0]          ld_fwd_mask,
  output logic                ld_stall,
  input  logic                dm_hold,
  output logic                dm_we,
  output logic [31:0]         dm_addr,
  output logic [31:0]         dm_wdata,
  output logic [3:0]          dm_be,
  output logic [4:0]          sb_count
);

  localparam int unsigned PW = $clog2(DEPTH);

  sb_entry_t                entries_q [DEPTH];
  logic [PW-1:0]            head_q, head_d;
  logic [PW-1:0]            tail_q, tail_d;
  logic [SB_CNT_W-1:0]      count_q, count_d;
  logic                     push, pop;
  logic [PW-1:0]            age [DEPTH];
  logic [DEPTH-1:0]         valid;
  logic [31:0]              merge_data;
  logic [SB_LANES-1:0]      merge_mask;
  logic                     merge_hit;
  logic                     unused_st_lo;

  assign unused_st_lo = ^st_addr[1:0];

  assign st_ready = (count_q != SB_CNT_W'(DEPTH));
  assign push     = st_valid && st_ready;
  assign dm_we    = (count_q != '0) && !dm_hold;
  assign pop      = dm_we;

  assign dm_addr  = {entries_q[head_q].addr, 2'b00};
  assign dm_wdata = entries_q[head_q].data;
  assign dm_be    = entries_q[head_q].be;
  assign sb_count = count_q;

  // Pointer and occupancy next-state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + PW'(1);
    if (pop)  head_d = head_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + SB_CNT_W'(1);
      2'b01:   count_d = count_q - SB_CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards buffered stores.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage written at the tail; residency is tracked by head/count.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      entries_q[tail_q] <= '{addr: st_addr[31:2], data: st_data, be: st_be};
    end
  end

  // Age relative to head (larger is younger) and residency per slot.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age[i]   = PW'(i) - head_q;
      valid[i] = (SB_CNT_W'(age[i]) < count_q);
    end
  end

  sb_fwd_merge #(.DEPTH(DEPTH)) u_merge (
    .entries_i  (entries_q),
    .valid_i    (valid),
    .age_i      (age),
    .ld_addr_i  (ld_addr),
    .fwd_data_o (merge_data),
    .fwd_mask_o (merge_mask),
    .hit_o      (merge_hit)
  );

`ifdef SB_FWD_EN
  logic unused_hit;
  assign unused_hit  = merge_hit;
  assign ld_fwd_data = ld_valid ? merge_data : '0;
  assign ld_fwd_mask = ld_valid ? merge_mask : '0;
  assign ld_stall    = 1'b0;
`else
  logic unused_fwd;
  assign unused_fwd  = ^{merge_data, merge_mask};
  assign ld_fwd_data = '0;
  assign ld_fwd_mask = '0;
  assign ld_stall    = ld_valid && merge_hit;
`endif

endmodule
